stack_arbiter: RTL and testbench

- Sequences a single-port LIFO memory of DEPTH x DW and shares it between two requesters, for example a debounced button/switch front end and a second producer/consumer.
- Owns the stack pointer, full/empty status, memory control signals and round-robin arbitration.
- Each push or pop is one req/done transaction; popped data is returned on a shared register.
- The memory is external to this block: synchronous write, synchronous read with 1-cycle read latency.

---
 rtl/stack_arbiter.sv | 110 +++++++++++
 tb/tb_stack_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
// Two-requester round-robin sequencer for an external single-port LIFO memory.
// Each push/pop is one req/done transaction; popped data is returned on rdata.
module stack_arbiter #(
   parameter int DW    = 8,
   parameter int AW    = 8,
   parameter int DEPTH = 256
) (
   input  logic          clk,
   input  logic          clr,
   input  logic [1:0]    req,
   input  logic [1:0]    op,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic [1:0]    done,
   output logic          err,
   output logic [DW-1:0] rdata,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [2:0] {IDLE, PUSH, POP, POPW, DONE} state_t;

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE      = (AW+1)'(1);

   state_t        state, nstate;
   logic          sel, op_q, rej, ptr;
   logic [DW-1:0] data_q;
   logic          gsel, gop, reject;
   logic [AW:0]   cnt_m1;

   assign full   = (count == FULL_CNT);
   assign empty  = (count == '0);
   assign cnt_m1 = count - ONE;

   // Contention goes to the pointer; a lone request wins outright.
   assign gsel   = (req == 2'b11) ? ptr : req[1];
   assign gop    = op[gsel];
   assign reject = gop ? empty : full;

   always_comb begin
      nstate = state;
      case (state)
         IDLE: if (|req) nstate = reject ? DONE : (gop ? POP : PUSH);
         PUSH: nstate = DONE;
         POP:  nstate = POPW;
         POPW: nstate = DONE;
         DONE: nstate = IDLE;
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      done      = '0;
      err       = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         PUSH: begin
            // A reset landing on the write cycle must not reach the memory.
            mem_we    = ~clr;
            mem_addr  = count[AW-1:0];
            mem_wdata = data_q;
         end
         POP:  mem_addr = cnt_m1[AW-1:0];
         DONE: begin
            done[sel] = 1'b1;
            err       = rej;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state  <= IDLE;
         count  <= '0;
         rdata  <= '0;
         ptr    <= 1'b0;
         sel    <= 1'b0;
         op_q   <= 1'b0;
         rej    <= 1'b0;
         data_q <= '0;
      end else begin
         state <= nstate;
         case (state)
            IDLE: if (|req) begin
               sel    <= gsel;
               op_q   <= gop;
               rej    <= reject;
               data_q <= gsel ? wdata1 : wdata0;
            end
            PUSH: count <= count + ONE;
            POPW: begin
               count <= cnt_m1;
               rdata <= mem_rdata;
            end
            DONE: ptr <= ~sel;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_arbiter.sv
// Scoreboarded bench for stack_arbiter with a DEPTH=4 synchronous memory model.
module tb_stack_arbiter;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic [1:0] req = '0;
   logic [1:0] op  = '0;
   logic [7:0] wdata0 = '0, wdata1 = '0;
   logic [1:0] done;
   logic       err;
   logic [7:0] rdata;
   logic [2:0] count;
   logic       full, empty, mem_we;
   logic [1:0] mem_addr;
   logic [7:0] mem_wdata, mem_rdata;

   stack_arbiter #(.DW(8), .AW(2), .DEPTH(4)) dut (
      .clk(clk), .clr(clr), .req(req), .op(op), .wdata0(wdata0), .wdata1(wdata1),
      .done(done), .err(err), .rdata(rdata), .count(count), .full(full), .empty(empty),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [4];
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   typedef struct packed {
      logic [1:0] d;
      logic       e;
      logic [7:0] rd;
      logic [2:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0, fails = 0;
   int   we_cnt = 0;
   logic [1:0] last_a;
   logic [7:0] last_d;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: memory write tracking and done-pulse scoreboard.
   always @(negedge clk) begin
      if (mem_we) begin
         we_cnt++;
         last_a = mem_addr;
         last_d = mem_wdata;
      end
      if (done != 2'b00) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("done_bits", 32'(done), 32'(e.d));
            check("err", 32'(err), 32'(e.e));
            check("rdata", 32'(rdata), 32'(e.rd));
            check("count", 32'(count), 32'(e.cnt));
         end
      end
   end

   task automatic do_op(input int i, input logic o, input logic [7:0] d, input logic e_err,
                        input logic [7:0] e_rd, input logic [2:0] e_cnt, input int e_lat);
      int  lat;
      logic got;
      exp_q.push_back('{d: (i == 1) ? 2'b10 : 2'b01, e: e_err, rd: e_rd, cnt: e_cnt});
      req[i] = 1'b1;
      op[i]  = o;
      if (i == 1) wdata1 = d; else wdata0 = d;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (done[i]) got = 1'b1;
      end
      check("latency", 32'(lat), 32'(e_lat));
      @(posedge clk);
      #1 req[i] = 1'b0;
   endtask

   task automatic do_reset();
      clr = 1'b1;
      repeat (2) @(posedge clk);
      #1 clr = 1'b0;
   endtask

   initial begin
      int n, w0;

      // Reset, then idle
      do_reset();
      check("rst_count", 32'(count), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      repeat (10) @(posedge clk);
      #1 check("idle_no_write", 32'(we_cnt), 32'd0);

      // Single push/pop on requester 0
      do_op(0, 1'b0, 8'h5A, 1'b0, 8'h00, 3'd1, 2);
      check("push_we_count", 32'(we_cnt), 32'd1);
      check("push_addr", 32'(last_a), 32'd0);
      check("push_data", 32'(last_d), 32'h5A);
      do_op(0, 1'b1, 8'h00, 1'b0, 8'h5A, 3'd0, 3);

      // LIFO order via requester 1
      do_op(1, 1'b0, 8'h11, 1'b0, 8'h5A, 3'd1, 2);
      do_op(1, 1'b0, 8'h22, 1'b0, 8'h5A, 3'd2, 2);
      do_op(1, 1'b0, 8'h33, 1'b0, 8'h5A, 3'd3, 2);
      do_op(1, 1'b1, 8'h00, 1'b0, 8'h33, 3'd2, 3);
      do_op(1, 1'b1, 8'h00, 1'b0, 8'h22, 3'd1, 3);
      do_op(1, 1'b1, 8'h00, 1'b0, 8'h11, 3'd0, 3);

      // Pop from empty: rejected, rdata held
      w0 = we_cnt;
      do_op(1, 1'b1, 8'h00, 1'b1, 8'h11, 3'd0, 1);
      check("empty_pop_flag", 32'(empty), 32'd1);
      check("empty_pop_no_write", 32'(we_cnt), 32'(w0));

      // Contention: both pushing continuously, grants must alternate
      do_reset();
      exp_q.push_back('{d: 2'b01, e: 1'b0, rd: 8'h00, cnt: 3'd1});
      exp_q.push_back('{d: 2'b10, e: 1'b0, rd: 8'h00, cnt: 3'd2});
      exp_q.push_back('{d: 2'b01, e: 1'b0, rd: 8'h00, cnt: 3'd3});
      exp_q.push_back('{d: 2'b10, e: 1'b0, rd: 8'h00, cnt: 3'd4});
      op = 2'b00; wdata0 = 8'hA0; wdata1 = 8'hB0; req = 2'b11;
      n = 0;
      for (int c = 0; c < 60 && n < 4; c++) begin
         @(negedge clk);
         if (done != 2'b00) n++;
      end
      @(posedge clk);
      #1 req = 2'b00;
      check("contention_dones", 32'(n), 32'd4);
      check("contention_full", 32'(full), 32'd1);
      check("mem0", 32'(mem[0]), 32'hA0);
      check("mem1", 32'(mem[1]), 32'hB0);
      check("mem2", 32'(mem[2]), 32'hA0);
      check("mem3", 32'(mem[3]), 32'hB0);

      // Fifth push into a full stack
      w0 = we_cnt;
      do_op(0, 1'b0, 8'hC5, 1'b1, 8'h00, 3'd4, 1);
      check("full_push_no_write", 32'(we_cnt), 32'(w0));
      check("full_flag", 32'(full), 32'd1);

      // Reset landing on the PUSH cycle
      do_reset();
      w0 = we_cnt;
      op[0] = 1'b0; wdata0 = 8'h77; req[0] = 1'b1;
      @(posedge clk);
      #1 clr = 1'b1; req[0] = 1'b0;
      #1 check("midrst_we", 32'(mem_we), 32'd0);
      @(posedge clk);
      #1 clr = 1'b0;
      check("midrst_count", 32'(count), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      repeat (6) @(posedge clk);
      #1 check("midrst_no_write", 32'(we_cnt), 32'(w0));
      check("midrst_mem0", 32'(mem[0]), 32'hA0);
      check("midrst_empty", 32'(empty), 32'd1);

      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
